// File: rtl/input_event_reader.sv
// Per-frame reader of button events from an input FIFO: pops one entry per frame tick,
// priority-encodes it into a one-hot command and counts the non-zero events.
module input_event_reader #(
    parameter int RD_LATENCY = 1
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       fifo_empty,
    input  logic [3:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] event_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        CAPTURE
    } state_t;

    // Final WAIT count; only meaningful when the FIFO needs more than one cycle.
    localparam logic [1:0] WAIT_LAST = (RD_LATENCY >= 2) ? 2'(RD_LATENCY - 2) : 2'd0;

    state_t     state;
    state_t     state_next;
    logic       pending;
    logic       pending_next;
    logic [1:0] wait_count;
    logic [1:0] wait_count_next;
    logic [3:0] cmd_next;
    logic       cmd_valid_next;
    logic [7:0] event_count_next;
    logic [3:0] priority_cmd;
    logic       start;

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            wait_count  <= 2'd0;
            cmd         <= 4'b0000;
            cmd_valid   <= 1'b0;
            event_count <= 8'd0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            wait_count  <= wait_count_next;
            cmd         <= cmd_next;
            cmd_valid   <= cmd_valid_next;
            event_count <= event_count_next;
        end
    end

    // up > down > left > right
    always_comb begin
        priority_cmd = 4'b0000;
        if (fifo_dout[3])      priority_cmd = 4'b1000;
        else if (fifo_dout[2]) priority_cmd = 4'b0100;
        else if (fifo_dout[1]) priority_cmd = 4'b0010;
        else if (fifo_dout[0]) priority_cmd = 4'b0001;
    end

    assign start = frame_tick | pending;

    always_comb begin
        state_next       = state;
        pending_next     = pending;
        wait_count_next  = wait_count;
        cmd_next         = cmd;
        cmd_valid_next   = cmd_valid;
        event_count_next = event_count;

        // A tick arriving mid-sequence is remembered once; extra ticks are dropped.
        if (state != IDLE && frame_tick) begin
            pending_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    pending_next = 1'b0;
                    if (!fifo_empty) begin
                        state_next = READ;
                    end else begin
                        cmd_next       = 4'b0000;
                        cmd_valid_next = 1'b0;
                    end
                end
            end
            READ: begin
                wait_count_next = 2'd0;
                if (RD_LATENCY > 1) state_next = WAIT;
                else                state_next = CAPTURE;
            end
            WAIT: begin
                if (wait_count == WAIT_LAST) begin
                    state_next = CAPTURE;
                end else begin
                    wait_count_next = wait_count + 2'd1;
                end
            end
            CAPTURE: begin
                state_next = IDLE;
                if (fifo_dout != 4'b0000) begin
                    cmd_next         = priority_cmd;
                    cmd_valid_next   = 1'b1;
                    event_count_next = event_count + 8'd1;
                end else begin
                    cmd_next       = 4'b0000;
                    cmd_valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fifo_rd_en = (state == READ);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_input_event_reader.sv
// Bench for input_event_reader: one instance at read latency 1 and one at latency 3, each
// fed by a FIFO model; captures are checked against a scoreboard of expected results.
module tb_input_event_reader;

    logic sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    logic       reset;
    logic       tick_a, empty_a, rd_a, valid_a, busy_a;
    logic [3:0] dout_a, cmd_a;
    logic [7:0] count_a;
    logic       tick_b, empty_b, rd_b, valid_b, busy_b;
    logic [3:0] dout_b, cmd_b;
    logic [7:0] count_b;

    input_event_reader #(.RD_LATENCY(1)) dut_a (
        .sys_clock(sys_clock), .reset(reset), .frame_tick(tick_a), .fifo_empty(empty_a),
        .fifo_dout(dout_a), .fifo_rd_en(rd_a), .cmd(cmd_a), .cmd_valid(valid_a),
        .event_count(count_a), .busy(busy_a)
    );

    input_event_reader #(.RD_LATENCY(3)) dut_b (
        .sys_clock(sys_clock), .reset(reset), .frame_tick(tick_b), .fifo_empty(empty_b),
        .fifo_dout(dout_b), .fifo_rd_en(rd_b), .cmd(cmd_b), .cmd_valid(valid_b),
        .event_count(count_b), .busy(busy_b)
    );

    typedef struct packed {
        logic [3:0] cmd;
        logic       valid;
        logic [7:0] count;
    } expect_t;

    typedef struct {
        logic [3:0] entry;
        logic [3:0] exp_cmd;
        logic       exp_valid;
    } vector_t;

    // Data seen on fifo_dout when no read is in flight; catches sampling at the wrong cycle.
    localparam logic [3:0] JUNK = 4'b0001;

    int         compared = 0;
    int         mismatched = 0;
    logic [3:0] q_a[$];
    logic [3:0] q_b[$];
    expect_t    sb_a[$];
    expect_t    sb_b[$];
    expect_t    head_a, head_b;
    logic [7:0] model_count_a = 8'd0;
    logic [7:0] model_count_b = 8'd0;
    logic [3:0] stage_b0, stage_b1;
    int         pops_b = 0;
    logic       prev_busy_a = 1'b0;
    logic       prev_busy_b = 1'b0;
    vector_t    vecs[8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] prio_cmd(input logic [3:0] e);
        if (e[3])      return 4'b1000;
        else if (e[2]) return 4'b0100;
        else if (e[1]) return 4'b0010;
        else if (e[0]) return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic expect_a(input logic [3:0] c, input logic v);
        if (v) model_count_a = model_count_a + 8'd1;
        sb_a.push_back({c, v, model_count_a});
    endtask

    task automatic expect_b(input logic [3:0] c, input logic v);
        if (v) model_count_b = model_count_b + 8'd1;
        sb_b.push_back({c, v, model_count_b});
    endtask

    task automatic applyStimulus(input bit use_b);
        if (use_b) tick_b = 1'b1;
        else       tick_a = 1'b1;
        @(posedge sys_clock); #1;
        tick_a = 1'b0;
        tick_b = 1'b0;
    endtask

    task automatic wait_drain(input bit use_b, input int budget);
        int n = 0;
        while (((use_b ? sb_b.size() : sb_a.size()) != 0 || (use_b ? busy_b : busy_a))
               && n < budget) begin
            @(posedge sys_clock); #1;
            n++;
        end
        checkOutput(use_b ? "drain_timeout_b" : "drain_timeout_a", (n >= budget) ? 1 : 0, 0);
    endtask

    // FIFO models: latency 1 presents data the cycle after the pop, latency 3 two cycles later.
    always @(posedge sys_clock) begin
        if (rd_a) begin
            if (q_a.size() == 0) begin
                compared++; mismatched++;
                $display("[TB] FAIL pop_a: got pop, expected none (fifo empty)");
                dout_a <= JUNK;
            end else begin
                dout_a <= q_a.pop_front();
            end
        end else begin
            dout_a <= JUNK;
        end
    end

    always @(posedge sys_clock) begin
        if (rd_b) begin
            pops_b = pops_b + 1;
            if (q_b.size() == 0) begin
                compared++; mismatched++;
                $display("[TB] FAIL pop_b: got pop, expected none (fifo empty)");
                stage_b0 <= JUNK;
            end else begin
                stage_b0 <= q_b.pop_front();
            end
        end else begin
            stage_b0 <= JUNK;
        end
        stage_b1 <= stage_b0;
        dout_b   <= stage_b1;
    end

    // A capture completes when busy falls outside reset.
    always @(negedge sys_clock) begin
        if (!reset && prev_busy_a && !busy_a) begin
            if (sb_a.size() == 0) begin
                compared++; mismatched++;
                $display("[TB] FAIL cap_a: got capture cmd=%0h, expected none", cmd_a);
            end else begin
                head_a = sb_a.pop_front();
                checkOutput("cap_a_cmd", cmd_a, head_a.cmd);
                checkOutput("cap_a_valid", valid_a, head_a.valid);
                checkOutput("cap_a_count", count_a, head_a.count);
            end
        end
        prev_busy_a = busy_a;
    end

    always @(negedge sys_clock) begin
        if (!reset && prev_busy_b && !busy_b) begin
            if (sb_b.size() == 0) begin
                compared++; mismatched++;
                $display("[TB] FAIL cap_b: got capture cmd=%0h, expected none", cmd_b);
            end else begin
                head_b = sb_b.pop_front();
                checkOutput("cap_b_cmd", cmd_b, head_b.cmd);
                checkOutput("cap_b_valid", valid_b, head_b.valid);
                checkOutput("cap_b_count", count_b, head_b.count);
            end
        end
        prev_busy_b = busy_b;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [3:0] e;
        vecs[0] = '{4'b1011, 4'b1000, 1'b1};
        vecs[1] = '{4'b0011, 4'b0010, 1'b1};
        vecs[2] = '{4'b0000, 4'b0000, 1'b0};
        vecs[3] = '{4'b0001, 4'b0001, 1'b1};
        vecs[4] = '{4'b1111, 4'b1000, 1'b1};
        vecs[5] = '{4'b0110, 4'b0100, 1'b1};
        vecs[6] = '{4'b0000, 4'b0000, 1'b0};
        vecs[7] = '{4'b0101, 4'b0100, 1'b1};

        reset = 1'b1;
        tick_a = 1'b0; tick_b = 1'b0;
        empty_a = 1'b1; empty_b = 1'b1;
        repeat (2) @(posedge sys_clock);
        #1;

        // Reset wins over a simultaneous frame tick.
        tick_a = 1'b1;
        @(posedge sys_clock); #1;
        tick_a = 1'b0;
        @(negedge sys_clock);
        checkOutput("rst_cmd_a", cmd_a, 0);
        checkOutput("rst_valid_a", valid_a, 0);
        checkOutput("rst_count_a", count_a, 0);
        checkOutput("rst_rd_a", rd_a, 0);
        checkOutput("rst_busy_a", busy_a, 0);
        checkOutput("rst_cmd_b", cmd_b, 0);
        checkOutput("rst_valid_b", valid_b, 0);
        checkOutput("rst_count_b", count_b, 0);
        checkOutput("rst_busy_b", busy_b, 0);
        @(posedge sys_clock); #1;
        reset = 1'b0;
        @(posedge sys_clock); #1;

        // Latency-1 timing: pop in cycle 1 only, outputs after the third edge.
        q_a.push_back(4'b0100);
        empty_a = 1'b0;
        expect_a(4'b0100, 1'b1);
        tick_a = 1'b1;
        @(negedge sys_clock);
        checkOutput("t33_rd_c0", rd_a, 0);
        @(posedge sys_clock); #1;
        tick_a = 1'b0;
        @(negedge sys_clock);
        checkOutput("t33_rd_c1", rd_a, 1);
        @(negedge sys_clock);
        checkOutput("t33_rd_c2", rd_a, 0);
        checkOutput("t33_cmd_c2", cmd_a, 0);
        @(negedge sys_clock);
        checkOutput("t33_cmd_c3", cmd_a, 4'b0100);
        checkOutput("t33_valid_c3", valid_a, 1);
        checkOutput("t33_count_c3", count_a, 1);
        @(posedge sys_clock); #1;
        empty_a = 1'b1;

        // Table of entries; empty is raised right after READ, which must not abort.
        for (int i = 0; i < 8; i++) begin
            q_a.push_back(vecs[i].entry);
            empty_a = 1'b0;
            expect_a(vecs[i].exp_cmd, vecs[i].exp_valid);
            applyStimulus(1'b0);
            empty_a = 1'b1;
            wait_drain(1'b0, 20);
        end

        // Empty start clears a held command without popping.
        checkOutput("t35_valid_before", valid_a, 1);
        tick_a = 1'b1;
        @(negedge sys_clock);
        checkOutput("t35_rd_c0", rd_a, 0);
        @(posedge sys_clock); #1;
        tick_a = 1'b0;
        @(negedge sys_clock);
        checkOutput("t35_cmd", cmd_a, 0);
        checkOutput("t35_valid", valid_a, 0);
        checkOutput("t35_rd_c1", rd_a, 0);
        checkOutput("t35_busy", busy_a, 0);
        checkOutput("t35_count", count_a, model_count_a);
        @(posedge sys_clock); #1;

        // Latency 3: tick while busy queues one more pop, a tick while pending is dropped.
        q_b.push_back(4'b1000);
        q_b.push_back(4'b0010);
        q_b.push_back(4'b0100);
        empty_b = 1'b0;
        pops_b = 0;
        expect_b(4'b1000, 1'b1);
        expect_b(4'b0010, 1'b1);
        tick_b = 1'b1;
        @(posedge sys_clock); #1;
        tick_b = 1'b0;
        @(posedge sys_clock); #1;
        tick_b = 1'b1;
        @(posedge sys_clock); #1;
        tick_b = 1'b0;
        @(posedge sys_clock); #1;
        tick_b = 1'b1;
        @(negedge sys_clock);
        checkOutput("t36_busy_c4", busy_b, 1);
        @(posedge sys_clock); #1;
        tick_b = 1'b0;
        @(negedge sys_clock);
        checkOutput("t36_busy_c5", busy_b, 0);
        checkOutput("t36_rd_c5", rd_b, 0);
        @(negedge sys_clock);
        checkOutput("t36_rd_c6", rd_b, 1);
        @(posedge sys_clock); #1;
        empty_b = 1'b1;
        wait_drain(1'b1, 30);
        repeat (5) @(posedge sys_clock);
        #1;
        checkOutput("t36_pops", pops_b, 2);
        checkOutput("t36_left", q_b.size(), 1);

        // Reset during WAIT abandons the sequence.
        q_b.delete();
        q_b.push_back(4'b0001);
        empty_b = 1'b0;
        tick_b = 1'b1;
        @(posedge sys_clock); #1;
        tick_b = 1'b0;
        empty_b = 1'b1;
        @(posedge sys_clock); #1;
        @(negedge sys_clock);
        checkOutput("t37_busy_wait", busy_b, 1);
        reset = 1'b1;
        @(posedge sys_clock); #1;
        @(negedge sys_clock);
        checkOutput("t37_cmd", cmd_b, 0);
        checkOutput("t37_valid", valid_b, 0);
        checkOutput("t37_count", count_b, 0);
        checkOutput("t37_busy", busy_b, 0);
        checkOutput("t37_rd", rd_b, 0);
        checkOutput("t37_count_a", count_a, 0);
        model_count_a = 8'd0;
        model_count_b = 8'd0;
        q_a.delete();
        q_b.delete();
        @(posedge sys_clock); #1;
        reset = 1'b0;
        q_b.push_back(4'b0100);
        empty_b = 1'b0;
        expect_b(4'b0100, 1'b1);
        applyStimulus(1'b1);
        empty_b = 1'b1;
        wait_drain(1'b1, 30);
        checkOutput("t37_restart_count", count_b, 1);

        // 256 non-zero events wrap the counter back to zero.
        for (int i = 0; i < 256; i++) begin
            e = 4'($urandom_range(1, 15));
            q_a.push_back(e);
            empty_a = 1'b0;
            expect_a(prio_cmd(e), 1'b1);
            applyStimulus(1'b0);
            empty_a = 1'b1;
            wait_drain(1'b0, 20);
        end
        checkOutput("t38_wrap", count_a, 0);
        checkOutput("t38_valid", valid_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/input_event_reader.md
INPUT_EVENT_READER -- requirements
Module: input_event_reader

Interface
REQ-001 The block SHALL have parameter RD_LATENCY, default 1, meaning the FIFO read latency in cycles from fifo_rd_en to valid fifo_dout; legal range 1..3.
REQ-002 sys_clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 frame_tick  input  1  single-cycle pulse once per video frame, the consume request.
REQ-005 fifo_empty  input  1  input FIFO empty flag.
REQ-006 fifo_dout  input  4  FIFO entry, button vector {up,down,left,right} = bits [3:0].
REQ-007 fifo_rd_en  output  1  single-cycle FIFO pop request.
REQ-008 cmd  output  4  one-hot command for the current frame; 4'b0000 = no command.
REQ-009 cmd_valid  output  1  high while cmd holds a command.
REQ-010 event_count  output  8  number of non-zero entries consumed, wraps 255->0.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, READ, WAIT, CAPTURE.
REQ-013 In IDLE, a start (frame_tick=1 or pending=1) with fifo_empty=0 SHALL go to READ next cycle and clear pending.
REQ-014 In IDLE, a start with fifo_empty=1 SHALL drive cmd=0 and cmd_valid=0 next cycle, stay in IDLE, and clear pending.
REQ-015 READ SHALL last exactly one cycle with fifo_rd_en=1; fifo_rd_en SHALL be 0 in every other state.
REQ-016 WAIT SHALL last RD_LATENCY-1 cycles; with RD_LATENCY=1 the FSM SHALL go from READ directly to CAPTURE.
REQ-017 CAPTURE SHALL sample fifo_dout, update cmd/cmd_valid/event_count at the end of that cycle, and return to IDLE.
REQ-018 Latency SHALL be frame_tick -> cmd update = RD_LATENCY+2 rising edges: IDLE->READ, READ->(WAIT...)->CAPTURE, CAPTURE->IDLE with outputs registered.
REQ-019 Capture rule: fifo_dout=0 SHALL give cmd=0, cmd_valid=0, and leave event_count unchanged.
REQ-020 Capture rule: a non-zero fifo_dout SHALL set cmd to the one-hot of the highest-priority set bit, priority up>down>left>right (bit3>bit2>bit1>bit0), set cmd_valid=1, and increment event_count by 1 modulo 256.
REQ-021 cmd and cmd_valid SHALL hold their value until the next capture, the next empty-start (REQ-014), or reset.
REQ-022 Exactly one FIFO entry SHALL be popped per start; at most one pop per frame_tick.
REQ-023 A frame_tick seen while busy=1 SHALL set a one-deep pending flag.
REQ-024 Further frame_ticks while pending=1 SHALL be dropped without effect.
REQ-025 pending SHALL be consumed as a start on the first IDLE cycle.
REQ-026 A frame_tick in the same cycle the FSM returns to IDLE SHALL be treated as a start.
REQ-027 A change of fifo_empty after READ SHALL NOT abort the sequence.
REQ-028 fifo_dout SHALL be sampled only in CAPTURE.
REQ-029 busy SHALL be combinational from the state register: 1 in READ, WAIT and CAPTURE.

Reset
REQ-030 Reset SHALL force, on the next edge: state=IDLE, pending=0, fifo_rd_en=0, cmd=0, cmd_valid=0, event_count=0, busy=0.
REQ-031 Reset SHALL take priority over frame_tick in the same cycle.
REQ-032 Reset asserted mid-sequence (READ/WAIT/CAPTURE) SHALL abandon the sequence with no capture and no count change; a pop already issued is not replayed.

Verification
REQ-033 RD_LATENCY=1, FIFO holds 4'b0100, frame_tick at cycle 0 -> fifo_rd_en=1 at cycle 1 only; cmd=4'b0100, cmd_valid=1, event_count=1 after the cycle-3 edge.
REQ-034 FIFO entry 4'b1011 -> cmd=4'b1000. Entry 4'b0011 -> cmd=4'b0010. Entry 4'b0000 -> cmd=0, cmd_valid=0, event_count unchanged.
REQ-035 fifo_empty=1 with cmd_valid=1 from the previous frame, frame_tick -> no fifo_rd_en; cmd=0, cmd_valid=0 after the next edge.
REQ-036 RD_LATENCY=3, frame_tick pulsed again while busy -> second pop issued immediately after return to IDLE; a third tick while pending is dropped, giving two pops total.
REQ-037 Reset asserted during WAIT -> all outputs 0 next cycle; a subsequent frame_tick restarts normally from IDLE.
REQ-038 256 non-zero entries consumed back-to-back -> event_count wraps to 0.
